// File: rtl/shift_arbiter.sv
// Round-robin sharing of one 32-bit left shifter between two requesters; 1-cycle latency to a
// one-entry output register, readys drop while it is full and stalled. SHIFT_ARB_RIGHT_EN adds logical-right.
module shift_arbiter_lsl #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic [WIDTH-1:0] target,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result
);
  assign result = target << shamt;
endmodule

module shift_arbiter #(
  parameter int WIDTH     = 32,
  parameter int SHW       = 5,
  parameter int PRIO_INIT = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_target,
  input  logic [SHW-1:0]   req0_shamt,
`ifdef SHIFT_ARB_RIGHT_EN
  input  logic             req0_dir,
`endif
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_target,
  input  logic [SHW-1:0]   req1_shamt,
`ifdef SHIFT_ARB_RIGHT_EN
  input  logic             req1_dir,
`endif
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_id,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nxt;
  logic             ptr;
  logic             grant0, grant1;
  logic             slot_free, accept, drain;
  logic [WIDTH-1:0] sel_target;
  logic [SHW-1:0]   sel_shamt;
  logic [WIDTH-1:0] shf_in, shf_out, shf_res;

  assign out_valid = (state == FULL);
  assign slot_free = !out_valid || out_ready;
  assign drain     = out_valid && out_ready;

  // Priority pointer only matters when both ports contend.
  assign grant0 = req0_valid && (!req1_valid || !ptr);
  assign grant1 = req1_valid && (!req0_valid || ptr);

  assign req0_ready = grant0 && slot_free;
  assign req1_ready = grant1 && slot_free;
  assign accept     = req0_ready || req1_ready;

  assign sel_target = grant1 ? req1_target : req0_target;
  assign sel_shamt  = grant1 ? req1_shamt  : req0_shamt;

`ifdef SHIFT_ARB_RIGHT_EN
  logic sel_dir;
  assign sel_dir = grant1 ? req1_dir : req0_dir;

  // Right shift = reverse, left shift, reverse back.
  always_comb begin
    shf_in  = sel_target;
    shf_res = shf_out;
    if (sel_dir) begin
      for (int i = 0; i < WIDTH; i++) begin
        shf_in[i]  = sel_target[WIDTH-1-i];
        shf_res[i] = shf_out[WIDTH-1-i];
      end
    end
  end
`else
  assign shf_in  = sel_target;
  assign shf_res = shf_out;
`endif

  shift_arbiter_lsl #(.WIDTH(WIDTH), .SHW(SHW)) u_lsl (
    .target (shf_in),
    .shamt  (sel_shamt),
    .result (shf_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (drain && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      ptr        <= 1'(PRIO_INIT);
      out_result <= '0;
      out_id     <= 1'b0;
      op_count   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_result <= shf_res;
        out_id     <= grant1;
        ptr        <= grant0;
      end
      if (drain) op_count <= op_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// Randomised and directed check of shift_arbiter against a rule-level reference model.
module tb_shift_arbiter;
  logic        clk, rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_target, req1_target, out_result;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        out_valid, out_ready, out_id;
  logic [3:0]  op_count;
`ifdef SHIFT_ARB_RIGHT_EN
  logic        req0_dir, req1_dir;
`endif

  int total = 0;
  int bad   = 0;

  bit          p_v[2];
  logic [31:0] p_t[2];
  logic [4:0]  p_s[2];
  bit          p_d[2];

  bit          m_valid;
  logic [31:0] m_result;
  bit          m_id;
  int          m_cnt;
  int          m_prio;
  int          served;

  shift_arbiter #(.WIDTH(32), .SHW(5), .PRIO_INIT(0), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_target (req0_target),
    .req0_shamt  (req0_shamt),
`ifdef SHIFT_ARB_RIGHT_EN
    .req0_dir    (req0_dir),
`endif
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_target (req1_target),
    .req1_shamt  (req1_shamt),
`ifdef SHIFT_ARB_RIGHT_EN
    .req1_dir    (req1_dir),
`endif
    .req1_ready  (req1_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_id      (out_id),
    .op_count    (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] t, input logic [4:0] s, input bit d);
    logic [31:0] r;
    if (d) r = t >> s;
    else   r = t << s;
    return r;
  endfunction

  task automatic drive();
    req0_valid  = p_v[0]; req0_target = p_t[0]; req0_shamt = p_s[0];
    req1_valid  = p_v[1]; req1_target = p_t[1]; req1_shamt = p_s[1];
`ifdef SHIFT_ARB_RIGHT_EN
    req0_dir = p_d[0]; req1_dir = p_d[1];
`endif
  endtask

  // One clock of traffic: check readys before the edge, advance the model, check outputs after.
  task automatic step(input bit ordy);
    bit free, g0, g1;
    int srv;
    drive();
    out_ready = ordy;
    #1;
    free = !m_valid || ordy;
    g0 = p_v[0] && (!p_v[1] || m_prio == 0);
    g1 = p_v[1] && (!p_v[0] || m_prio == 1);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0 && free});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1 && free});
    srv = -1;
    if (free && g0) srv = 0;
    else if (free && g1) srv = 1;
    @(posedge clk);
    if (m_valid && ordy) m_cnt = (m_cnt + 1) % 16;
    if (srv >= 0) begin
      m_result = ref_shift(p_t[srv], p_s[srv], p_d[srv]);
      m_id     = (srv == 1);
      m_valid  = 1'b1;
      m_prio   = 1 - srv;
      p_v[srv] = 1'b0;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    served = srv;
    #1;
    chk("out_valid",  {31'd0, out_valid}, {31'd0, m_valid});
    chk("out_id",     {31'd0, out_id},    {31'd0, m_id});
    chk("out_result", out_result,         m_result);
    chk("op_count",   {28'd0, op_count},  m_cnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    p_v[0] = 1'b0; p_v[1] = 1'b0; p_d[0] = 1'b0; p_d[1] = 1'b0;
    drive();
    #1;
    chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result,         32'd0);
    chk("rst_out_id",     {31'd0, out_id},    32'd0);
    chk("rst_op_count",   {28'd0, op_count},  32'd0);
    m_valid = 1'b0; m_result = '0; m_id = 1'b0; m_cnt = 0; m_prio = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input int n, input logic [31:0] t, input logic [4:0] s, input bit d);
    p_v[n] = 1'b1; p_t[n] = t; p_s[n] = s; p_d[n] = d;
  endtask

  initial begin
    rst_n = 1'b1; out_ready = 1'b0;
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    p_t[0] = '0; p_t[1] = '0; p_s[0] = '0; p_s[1] = '0; p_d[0] = 1'b0; p_d[1] = 1'b0;
    served = -1;
    drive();
    #1;
    do_reset();

    // Contention from reset: grants alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      set_req(0, 32'hFFFF_FFFF, 5'd4, 1'b0);
      set_req(1, 32'h1234_5678, 5'd0, 1'b0);
      step(1'b1);
      chk("contend_id", {31'd0, out_id}, i % 2);
      chk("contend_res", out_result, (i % 2 == 0) ? 32'hFFFF_FFF0 : 32'h1234_5678);
    end
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    step(1'b1);

    // Single op, shamt at its maximum.
    set_req(0, 32'h0000_0001, 5'd31, 1'b0);
    step(1'b1);
    chk("single_res", out_result, 32'h8000_0000);
    chk("single_id", {31'd0, out_id}, 32'd0);
    step(1'b1);
    chk("single_cnt", {28'd0, op_count}, 32'd5);

    // Back-pressure: full register, stalled consumer, pending req1.
    set_req(0, 32'h0000_00F1, 5'd4, 1'b0);
    step(1'b0);
    set_req(1, 32'hA5A5_0000, 5'd8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
      chk("bp_hold", out_result, 32'h0000_0F10);
    end
    step(1'b1);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_id", {31'd0, out_id}, 32'd1);
    chk("bp_res", out_result, 32'hA500_0000);

    // Asynchronous reset while a result is held.
    set_req(0, 32'h0000_0003, 5'd1, 1'b0);
    step(1'b0);
    #2;
    do_reset();

    // 17 drained ops on a 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      set_req(0, 32'(i), 5'(i), 1'b0);
      step(1'b1);
    end
    step(1'b1);
    chk("wrap_cnt", {28'd0, op_count}, 32'd1);

`ifdef SHIFT_ARB_RIGHT_EN
    set_req(0, 32'h8000_0000, 5'd31, 1'b1);
    step(1'b1);
    chk("right_31", out_result, 32'h0000_0001);
    set_req(1, 32'hDEAD_BEEF, 5'd0, 1'b1);
    step(1'b1);
    chk("right_0", out_result, 32'hDEAD_BEEF);
`endif

    // Random traffic; a request stays stable until the model sees it accepted.
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!p_v[n] && $urandom_range(0, 2) != 0) begin
          case ($urandom_range(0, 3))
            0:       p_t[n] = 32'hFFFF_FFFF;
            1:       p_t[n] = 32'h0000_0001;
            default: p_t[n] = $urandom;
          endcase
          p_s[n] = 5'($urandom_range(0, 31));
`ifdef SHIFT_ARB_RIGHT_EN
          p_d[n] = 1'($urandom_range(0, 1));
`endif
          p_v[n] = 1'b1;
        end
      end
      step($urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one combinational 32-bit logical-left shifter (target, shamt -> result) between two requesters, e.g. the ALU sll path and the multiplier/normaliser.
- Round-robin arbitration, valid/ready handshake on each request port.
- One-entry registered output stage with valid/ready back-pressure.
- Sits between the requesting units and the shifter; the shifter is instantiated inside this block.

Parameters:
WIDTH, 32, datapath width; must stay 32 to match the shifter
SHW, 5, shift-amount width
PRIO_INIT, 0, requester that holds priority after reset (0 or 1)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_target  input  WIDTH  requester 0 operand
req0_shamt  input  SHW  requester 0 shift amount
req0_ready  output  1  requester 0 operation accepted this cycle
req1_valid  input  1  requester 1 has an operation
req1_target  input  WIDTH  requester 1 operand
req1_shamt  input  SHW  requester 1 shift amount
req1_ready  output  1  requester 1 operation accepted this cycle
out_valid  output  1  out_result holds a valid result
out_ready  input  1  consumer takes the result
out_result  output  WIDTH  shifted value
out_id  output  1  requester that owns out_result
op_count  output  CNT_W  number of completed (drained) operations

Behaviour:
- Reset (rst_n low, asynchronous) forces the following values, held while rst_n is low: out_valid=0, out_result=0, out_id=0, op_count=0, priority pointer=PRIO_INIT.
- Reset mid-operation discards any held result; nothing is replayed after reset.
- Define slot_free = !out_valid || out_ready, so a full output register is replaced in the same cycle it drains.
- Grant is combinational from req*_valid and the pointer:
  - Only one valid: that requester is granted.
  - Both valid: the pointer requester is granted.
  - Neither valid: no grant.
- reqN_ready = grant_N && slot_free. At most one ready is high per cycle. Ready does not depend on reqN_valid of the same port, apart from through the grant.
- Accept = valid && ready on the granted port in cycle N.
  - At the clock edge: out_result <= shift(target, shamt), out_id <= N's port, out_valid <= 1.
  - Latency: out_valid is high from cycle N+1.
- Shift arithmetic:
  - Logical left: result = (target << shamt) truncated to WIDTH, zero fill.
  - shamt=0 passes the operand through unchanged.
  - shamt=31 keeps only bit 0, moved to bit 31.
- Pointer update occurs only on an accept: the pointer moves to the requester that was not served. With no accept the pointer holds.
- Drain (out_valid && out_ready):
  - op_count increments by 1 and wraps 2^CNT_W-1 -> 0.
  - If there is no simultaneous accept, out_valid <= 0; out_result and out_id hold their stale values.
- Simultaneous drain and accept: out_valid stays 1, new data is loaded and op_count increments. This sustains 1 op/cycle.
- Output stall (out_valid=1, out_ready=0): both readys are 0. out_result and out_id are held stable. Requesters must keep valid and data stable until ready.
- State machine with two states:
  - EMPTY (out_valid=0): accept -> FULL.
  - FULL: drain without accept -> EMPTY; drain with accept -> FULL; stall -> FULL.

Optional Feature:
Macro SHIFT_ARB_RIGHT_EN.
- Defined:
  - Adds input ports req0_dir and req1_dir (1 bit each; 0 = left, 1 = logical right).
  - The dir bit is captured with the operand on accept.
  - Right shift reuses the single left shifter: bit-reverse the operand, left-shift, bit-reverse the result. Zero fill from the MSB.
  - Latency is unchanged.
- Undefined: the dir ports do not exist and every operation is a logical left shift.

Test Plan:
- Reset: rst_n=0 asserted mid-stream, with out_valid previously 1 -> out_valid=0, op_count=0, out_result=0 immediately, without waiting for a clock edge.
- Single op: req0 target=32'h0000_0001, shamt=31, out_ready=1 -> next cycle out_result=32'h8000_0000, out_id=0; op_count=1 one cycle later.
- Contention with PRIO_INIT=0: both valid every cycle, out_ready=1 -> grants alternate 0,1,0,1. req0 target=32'hFFFF_FFFF shamt=4 gives 32'hFFFF_FFF0; req1 target=32'h1234_5678 shamt=0 gives 32'h1234_5678.
- Back-pressure: out_ready=0 for 3 cycles with req1 valid -> req1_ready=0 and out_result held. When out_ready=1 there is drain plus accept in the same cycle, and out_valid stays 1.
- Counter wrap with CNT_W=4: 17 drained ops -> op_count=1.
- SHIFT_ARB_RIGHT_EN: dir=1, target=32'h8000_0000, shamt=31 -> 32'h0000_0001; dir=1, shamt=0 -> operand unchanged.
